// File: rtl/cook_stage_sequencer_pkg.sv
// cook_stage_sequencer_pkg -- shared state encoding and mm:ss constants for the cook stage sequencer.
// Revision 1.0
`default_nettype none

package cook_stage_sequencer_pkg;

  localparam int MMSS_W         = 16;
  localparam int NUM_STAGES_DEF = 4;
  localparam int ALARM_SEC_DEF  = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_ALARM = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cook_stage_sequencer_bcd_mmss_step.sv
// bcd_mmss_step -- BCD mm:ss field increment (00-59 wrap) and whole-value one-second decrement.
// Revision 1.0
`default_nettype none

module bcd_mmss_step
  import cook_stage_sequencer_pkg::*;
(
  input  logic [MMSS_W-1:0] mmss_i,
  output logic [7:0]        sec_inc_o,
  output logic [7:0]        min_inc_o,
  output logic [MMSS_W-1:0] dec_o
);

  function automatic logic [7:0] field_inc(input logic [7:0] f);
    if (f[3:0] == 4'd9)
      field_inc = (f[7:4] == 4'd5) ? 8'h00 : {f[7:4] + 4'd1, 4'd0};
    else
      field_inc = {f[7:4], f[3:0] + 4'd1};
  endfunction

  assign sec_inc_o = field_inc(mmss_i[7:0]);
  assign min_inc_o = field_inc(mmss_i[15:8]);

  // Saturates at 00:00; borrows ripple sec1 -> sec10 -> min1 -> min10.
  always_comb begin
    dec_o = mmss_i;
    if (mmss_i != '0) begin
      if (mmss_i[3:0] != 4'd0) begin
        dec_o[3:0] = mmss_i[3:0] - 4'd1;
      end else begin
        dec_o[3:0] = 4'd9;
        if (mmss_i[7:4] != 4'd0) begin
          dec_o[7:4] = mmss_i[7:4] - 4'd1;
        end else begin
          dec_o[7:4] = 4'd5;
          if (mmss_i[11:8] != 4'd0) begin
            dec_o[11:8] = mmss_i[11:8] - 4'd1;
          end else begin
            dec_o[11:8]  = 4'd9;
            dec_o[15:12] = mmss_i[15:12] - 4'd1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cook_stage_sequencer.sv
// cook_stage_sequencer -- programmable multi-stage cook timer controller driving an external BCD down counter.
// Revision 1.0
`default_nettype none

module cook_stage_sequencer
  import cook_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int ALARM_SEC  = ALARM_SEC_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [3:0]        btn_pe,
  input  logic              tick_sec,
  input  logic              timer_zero,
  output logic              load_en,
  output logic [MMSS_W-1:0] load_value,
  output logic              run_en,
  output logic [MMSS_W-1:0] disp_value,
  output logic [7:0]        led
);

  localparam int IDX_W  = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int ACNT_W = $clog2(ALARM_SEC + 1);

  state_e              state_q, state_d;
  logic [MMSS_W-1:0]   stage_q [NUM_STAGES];
  logic [MMSS_W-1:0]   stage_d [NUM_STAGES];
  logic [IDX_W-1:0]    edit_q, edit_d, cur_q, cur_d;
  logic [ACNT_W-1:0]   acnt_q, acnt_d;
  logic [MMSS_W-1:0]   shadow_q, shadow_d;
  logic                first_q;
  logic                load_en_q, load_en_d, run_en_q, run_en_d;
  logic [MMSS_W-1:0]   load_value_q, load_value_d, disp_q, disp_d;
  logic [7:0]          led_q, led_d;

  logic [MMSS_W-1:0]   step_in, step_dec;
  logic [7:0]          step_sec_inc, step_min_inc;
  logic                start_found, adv_found;
  logic [IDX_W-1:0]    start_idx, adv_idx, led_idx;

  // Editing only happens in IDLE and the shadow only counts in RUN, so one stepper serves both.
  assign step_in = (state_q == ST_IDLE) ? stage_q[edit_q] : shadow_q;

  bcd_mmss_step u_step (
    .mmss_i    (step_in),
    .sec_inc_o (step_sec_inc),
    .min_inc_o (step_min_inc),
    .dec_o     (step_dec)
  );

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    edit_d      = edit_q;
    cur_d       = cur_q;
    acnt_d      = acnt_q;
    shadow_d    = shadow_q;
    start_found = 1'b0;
    start_idx   = '0;
    adv_found   = 1'b0;
    adv_idx     = '0;

    if (state_q == ST_IDLE) begin
      if (btn_pe[1]) stage_d[edit_q][7:0]  = step_sec_inc;
      if (btn_pe[2]) stage_d[edit_q][15:8] = step_min_inc;
    end
    if (state_q == ST_RUN && tick_sec) shadow_d = step_dec;

    for (int i = 0; i < NUM_STAGES; i++) begin
      if (!start_found && stage_d[i] != '0) begin
        start_found = 1'b1;
        start_idx   = IDX_W'(i);
      end
      if (!adv_found && stage_d[i] != '0 && IDX_W'(i) > cur_q) begin
        adv_found = 1'b1;
        adv_idx   = IDX_W'(i);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (btn_pe[3]) edit_d = (edit_q == IDX_W'(NUM_STAGES - 1)) ? '0 : edit_q + 1'b1;
        if (btn_pe[0] && start_found) begin
          state_d = ST_LOAD;
          cur_d   = start_idx;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (btn_pe[3]) begin
          state_d = ST_IDLE;
        end else if (timer_zero && !first_q) begin
          if (adv_found) begin
            state_d = ST_LOAD;
            cur_d   = adv_idx;
          end else begin
            state_d = ST_ALARM;
          end
        end else if (btn_pe[0]) begin
          state_d = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (btn_pe[3])      state_d = ST_IDLE;
        else if (btn_pe[0]) state_d = ST_RUN;
      end
      ST_ALARM: begin
        if (|btn_pe) begin
          state_d = ST_IDLE;
        end else if (tick_sec) begin
          if (acnt_q == ACNT_W'(ALARM_SEC - 1)) state_d = ST_IDLE;
          else                                  acnt_d  = acnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_IDLE && state_q != ST_IDLE) begin
      edit_d = '0;
      cur_d  = '0;
    end
    if (state_d != ST_ALARM) acnt_d = '0;
    if (state_d == ST_LOAD) shadow_d = stage_d[cur_d];

    // Outputs are computed from next-state values so the registered copies line up with state_q.
    load_en_d    = (state_d == ST_LOAD);
    load_value_d = (state_d == ST_LOAD) ? stage_d[cur_d] : load_value_q;
    run_en_d     = (state_d == ST_RUN);
    case (state_d)
      ST_IDLE:           disp_d = stage_d[edit_d];
      ST_LOAD:           disp_d = stage_d[cur_d];
      ST_RUN, ST_PAUSE:  disp_d = shadow_d;
      default:           disp_d = '0;
    endcase
    led_idx = (state_d == ST_IDLE) ? edit_d : cur_d;
    led_d   = 8'h00;
    for (int i = 0; i < NUM_STAGES; i++) led_d[i] = (led_idx == IDX_W'(i));
    led_d[4] = (state_d == ST_RUN);
    led_d[5] = (state_d == ST_PAUSE);
    led_d[7] = (state_d == ST_ALARM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      for (int i = 0; i < NUM_STAGES; i++) stage_q[i] <= '0;
      edit_q       <= '0;
      cur_q        <= '0;
      acnt_q       <= '0;
      shadow_q     <= '0;
      first_q      <= 1'b0;
      load_en_q    <= 1'b0;
      load_value_q <= '0;
      run_en_q     <= 1'b0;
      disp_q       <= '0;
      led_q        <= 8'h01;
    end else begin
      state_q      <= state_d;
      stage_q      <= stage_d;
      edit_q       <= edit_d;
      cur_q        <= cur_d;
      acnt_q       <= acnt_d;
      shadow_q     <= shadow_d;
      first_q      <= (state_q == ST_LOAD);
      load_en_q    <= load_en_d;
      load_value_q <= load_value_d;
      run_en_q     <= run_en_d;
      disp_q       <= disp_d;
      led_q        <= led_d;
    end
  end

  assign load_en    = load_en_q;
  assign load_value = load_value_q;
  assign run_en     = run_en_q;
  assign disp_value = disp_q;
  assign led        = led_q;

endmodule

`default_nettype wire

// File: tb/tb_cook_stage_sequencer.sv
// tb_cook_stage_sequencer -- directed, table-driven checks of the cook stage sequencer.
// Revision 1.0
`default_nettype none

module tb_cook_stage_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  btn_pe;
  logic        tick_sec;
  logic        timer_zero;
  logic        load_en;
  logic [15:0] load_value;
  logic        run_en;
  logic [15:0] disp_value;
  logic [7:0]  led;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cook_stage_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .btn_pe     (btn_pe),
    .tick_sec   (tick_sec),
    .timer_zero (timer_zero),
    .load_en    (load_en),
    .load_value (load_value),
    .run_en     (run_en),
    .disp_value (disp_value),
    .led        (led)
  );

  typedef struct {
    logic [3:0]  btn;
    logic        tick;
    logic        tz;
    logic        le;
    logic [15:0] lv;
    logic        re;
    logic [15:0] disp;
    logic [7:0]  led;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else             n_pass++;
  endtask

  task automatic chk_outs(input string nm, input logic le, input logic [15:0] lv, input logic re,
                          input logic [15:0] d, input logic [7:0] l);
    chk({nm, ".load_en"},    {15'd0, load_en}, {15'd0, le});
    chk({nm, ".load_value"}, load_value, lv);
    chk({nm, ".run_en"},     {15'd0, run_en}, {15'd0, re});
    chk({nm, ".disp"},       disp_value, d);
    chk({nm, ".led"},        {8'd0, led}, {8'd0, l});
  endtask

  task automatic step(input logic [3:0] b, input logic tk, input logic tz);
    @(negedge clk);
    btn_pe     = b;
    tick_sec   = tk;
    timer_zero = tz;
    @(posedge clk);
    #1;
  endtask

  task automatic vec(input string nm, input logic [3:0] b, input logic tk, input logic tz,
                     input logic le, input logic [15:0] lv, input logic re,
                     input logic [15:0] d, input logic [7:0] l);
    step(b, tk, tz);
    chk_outs(nm, le, lv, re, d, l);
  endtask

  initial begin
    reset_n    = 1'b0;
    btn_pe     = 4'b0000;
    tick_sec   = 1'b0;
    timer_zero = 1'b0;

    // Stage0 = 00:03 run to alarm, then the 10-tick alarm timeout.
    tbl[0] = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0001, 8'h01};
    tbl[1] = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 8'h01};
    tbl[2] = '{4'b0010, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0003, 8'h01};
    tbl[3] = '{4'b0001, 1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0003, 8'h01};
    tbl[4] = '{4'b0000, 1'b0, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0003, 8'h11};
    tbl[5] = '{4'b0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0002, 8'h11};
    tbl[6] = '{4'b0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0001, 8'h11};
    tbl[7] = '{4'b0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b1, 16'h0000, 8'h11};
    tbl[8] = '{4'b0000, 1'b0, 1'b1, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'h81};
    for (int i = 9; i < 18; i++)
      tbl[i] = '{4'b0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0000, 8'h81};
    tbl[18] = '{4'b0000, 1'b1, 1'b0, 1'b0, 16'h0003, 1'b0, 16'h0003, 8'h01};

    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 19; i++)
      vec($sformatf("tbl%0d", i), tbl[i].btn, tbl[i].tick, tbl[i].tz,
          tbl[i].le, tbl[i].lv, tbl[i].re, tbl[i].disp, tbl[i].led);

    // Seconds wrap 59 -> 00 without touching minutes; 60 presses return to start.
    repeat (56) step(4'b0010, 1'b0, 1'b0);
    vec("sec_wrap", 4'b0010, 0, 0, 0, 16'h0003, 0, 16'h0000, 8'h01);
    vec("min_inc",  4'b0100, 0, 0, 0, 16'h0003, 0, 16'h0100, 8'h01);
    repeat (59) step(4'b0010, 1'b0, 1'b0);
    vec("sec60",    4'b0010, 0, 0, 0, 16'h0003, 0, 16'h0100, 8'h01);
    vec("sel1",     4'b1000, 0, 0, 0, 16'h0003, 0, 16'h0000, 8'h02);
    vec("sel2",     4'b1000, 0, 0, 0, 16'h0003, 0, 16'h0000, 8'h04);
    repeat (4) step(4'b0010, 1'b0, 1'b0);
    vec("st2_05",   4'b0010, 0, 0, 0, 16'h0003, 0, 16'h0005, 8'h04);

    // Multi-stage run: stage1 at 00:00 is skipped.
    vec("load0",    4'b0001, 0, 0, 1, 16'h0100, 0, 16'h0100, 8'h01);
    vec("run0",     4'b0000, 0, 0, 0, 16'h0100, 1, 16'h0100, 8'h11);
    vec("tz_first", 4'b0000, 1, 1, 0, 16'h0100, 1, 16'h0059, 8'h11);
    vec("load2",    4'b0000, 0, 1, 1, 16'h0005, 0, 16'h0005, 8'h04);
    vec("run2",     4'b0000, 0, 0, 0, 16'h0005, 1, 16'h0005, 8'h14);
    vec("run2_tk",  4'b0000, 1, 0, 0, 16'h0005, 1, 16'h0004, 8'h14);
    vec("pause",    4'b0001, 0, 0, 0, 16'h0005, 0, 16'h0004, 8'h24);
    vec("pause_tk", 4'b0000, 1, 0, 0, 16'h0005, 0, 16'h0004, 8'h24);
    vec("pause_ed", 4'b0010, 0, 0, 0, 16'h0005, 0, 16'h0004, 8'h24);
    vec("resume",   4'b0001, 0, 0, 0, 16'h0005, 1, 16'h0004, 8'h14);
    vec("tz_vs_st", 4'b0001, 0, 1, 0, 16'h0005, 0, 16'h0000, 8'h84);
    vec("alarm_bt", 4'b0010, 0, 0, 0, 16'h0005, 0, 16'h0100, 8'h01);

    // Cancel beats timer_zero and start in the same cycle.
    vec("load_c",   4'b0001, 0, 0, 1, 16'h0100, 0, 16'h0100, 8'h01);
    vec("run_c",    4'b0000, 0, 0, 0, 16'h0100, 1, 16'h0100, 8'h11);
    vec("cancel",   4'b1001, 0, 1, 0, 16'h0100, 0, 16'h0100, 8'h01);
    vec("persist1", 4'b1000, 0, 0, 0, 16'h0100, 0, 16'h0000, 8'h02);
    vec("persist2", 4'b1000, 0, 0, 0, 16'h0100, 0, 16'h0005, 8'h04);

    // Cancel out of PAUSE.
    vec("load_p",   4'b0001, 0, 0, 1, 16'h0100, 0, 16'h0100, 8'h01);
    vec("run_p",    4'b0000, 0, 0, 0, 16'h0100, 1, 16'h0100, 8'h11);
    vec("pause_p",  4'b0001, 0, 0, 0, 16'h0100, 0, 16'h0100, 8'h21);
    vec("cancel_p", 4'b1000, 0, 0, 0, 16'h0100, 0, 16'h0100, 8'h01);

    // Asynchronous reset in the middle of RUN.
    vec("load_r",   4'b0001, 0, 0, 1, 16'h0100, 0, 16'h0100, 8'h01);
    vec("run_r",    4'b0000, 0, 0, 0, 16'h0100, 1, 16'h0100, 8'h11);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 16'h0000, 1'b0, 16'h0000, 8'h01);
    @(negedge clk);
    reset_n = 1'b1;
    vec("post_rst1", 4'b0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 8'h01);
    vec("post_rst2", 4'b0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 8'h01);
    vec("zero_start",4'b0001, 0, 0, 0, 16'h0000, 0, 16'h0000, 8'h01);
    vec("zero_idle", 4'b0000, 0, 0, 0, 16'h0000, 0, 16'h0000, 8'h01);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cook_stage_sequencer.md
COOK_STAGE_SEQUENCER -- requirements
Module: cook_stage_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of programmable cook stages.
REQ-002 SHALL have parameter ALARM_SEC, default 10, seconds the end alarm stays on before auto-clear.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port btn_pe  input  4  debounced one-cycle button pulses: [0] start/pause, [1] sec+, [2] min+, [3] stage-select/cancel.
REQ-006 SHALL have port tick_sec  input  1  one-cycle 1 Hz pulse from the prescaler chain.
REQ-007 SHALL have port timer_zero  input  1  level from the external loadable BCD down counter; 1 when it reads 00:00.
REQ-008 SHALL have port load_en  output  1  one-cycle load strobe to the down counter.
REQ-009 SHALL have port load_value  output  16  BCD {min10,min1,sec10,sec1} to load.
REQ-010 SHALL have port run_en  output  1  enables tick_sec into the down counter.
REQ-011 SHALL have port disp_value  output  16  BCD time for the FND controller.
REQ-012 SHALL have port led  output  8  [NUM_STAGES-1:0] one-hot current stage, [4] running, [5] paused, [7] alarm, [6] 0.

Function
REQ-013 SHALL implement FSM states IDLE, LOAD, RUN, PAUSE, ALARM.
REQ-014 SHALL hold NUM_STAGES stage times as 16-bit BCD mm:ss, each field 00-59.
REQ-015 In IDLE, btn_pe[3] SHALL advance the edit stage index, wrapping NUM_STAGES-1 -> 0.
REQ-016 In IDLE, btn_pe[1]/[2] SHALL increment seconds/minutes of the edit stage, BCD, 59 -> 00 wrap, no carry between fields.
REQ-017 sec+/min+ outside IDLE SHALL be ignored; stage times SHALL persist across runs.
REQ-018 In IDLE, btn_pe[0] SHALL go to LOAD with the lowest-index nonzero stage; if all stages are 00:00, stay in IDLE.
REQ-019 LOAD SHALL last exactly one cycle with load_en=1, load_value=current stage time, then go to RUN.
REQ-020 RUN SHALL drive run_en=1 and SHALL ignore timer_zero in its first cycle after LOAD.
REQ-021 In RUN, timer_zero=1 SHALL go to LOAD of the next higher-index nonzero stage (00:00 stages skipped); if none, go to ALARM.
REQ-022 In RUN, btn_pe[0] SHALL go to PAUSE (run_en=0); in PAUSE, btn_pe[0] SHALL return to RUN without reload.
REQ-023 In RUN or PAUSE, btn_pe[3] SHALL cancel to IDLE with run_en=0.
REQ-024 Priority SHALL be: btn_pe[3] cancel > timer_zero > btn_pe[0]; sec+/min+ in the same cycle as start SHALL still apply in IDLE.
REQ-025 ALARM SHALL hold led[7]=1, count tick_sec, and return to IDLE after ALARM_SEC ticks or on any btn_pe bit (that press not otherwise acted on).
REQ-026 disp_value SHALL be the edit stage time in IDLE, the current stage time in LOAD, and 16'h0000 in ALARM; in RUN/PAUSE it SHALL be the value last loaded minus elapsed ticks, tracked by an internal BCD shadow.
REQ-027 Entering IDLE SHALL set the edit stage index to 0.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 On reset_n=0: state=IDLE, all stage times 00:00, edit/current index 0, alarm counter 0.
REQ-030 On reset_n=0: load_en=0, run_en=0, load_value=0, disp_value=0, led=8'h01.
REQ-031 Reset asserted mid-RUN or mid-ALARM SHALL abort immediately; no load_en pulse SHALL follow release.

Structure
REQ-032 A shared package SHALL hold the state enumeration, the BCD mm:ss width constant, and default NUM_STAGES/ALARM_SEC.
REQ-033 A sub-module bcd_mmss_step SHALL provide BCD field increment (00-59 wrap) and mm:ss decrement, used for editing and the display shadow.

Verification
REQ-034 Stage0=00:03, others 0, start -> one load_en with 16'h0003; timer_zero after 3 ticks -> ALARM, led[7]=1, IDLE after 10 ticks.
REQ-035 Stage0=01:00, stage1=0, stage2=00:05, start, drive timer_zero -> load 16'h0100, then load 16'h0005 (stage1 skipped), led one-hot 0001 then 0100.
REQ-036 IDLE, 60 sec+ pulses on stage0 -> 00:00 (wrap), minutes unchanged; all stages zero + start -> stays IDLE, no load_en.
REQ-037 RUN, start -> PAUSE, run_en=0, led[5]=1; start -> RUN, no load_en; cancel -> IDLE, run_en=0.
REQ-038 timer_zero and btn_pe[0] same RUN cycle -> stage advance, no PAUSE; with btn_pe[3] also -> IDLE.
REQ-039 reset_n low mid-RUN -> all outputs at reset values asynchronously; after release, no load_en until start.
